// File: rtl/osc_pkg.sv
// Shared oscilloscope types: sample word, 80-sample frame, capture FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package osc_pkg;

    localparam int SAMPLE_W = 12;
    localparam int SAMPLES  = 80;

    typedef logic [SAMPLE_W-1:0] sample_t;
    typedef sample_t frame_t [0:SAMPLES-1];

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_PUBLISH = 2'd3
    } capture_state_t;

endpackage

// File: rtl/sample_capture_trigger_detect.sv
// Level-crossing detector: rising (prev < lvl <= cur) or falling (prev > lvl >= cur).
// Latency: combinational, same cycle.
// Backpressure: none; qualified by the caller with sample_valid.
module trigger_detect #(
    parameter int WIDTH = 12
) (
    input  logic [WIDTH-1:0] prev,
    input  logic             prev_valid,
    input  logic [WIDTH-1:0] sample_in,
    input  logic [WIDTH-1:0] trig_level,
    input  logic             trig_falling,
    output logic             hit
);

    logic rise_hit;
    logic fall_hit;

    // Unsigned same-width compares; extreme levels make one direction unreachable.
    always_comb begin
        rise_hit = (prev < trig_level) && (sample_in >= trig_level);
        fall_hit = (prev > trig_level) && (sample_in <= trig_level);
        hit      = prev_valid && (trig_falling ? fall_hit : rise_hit);
    end

endmodule

// File: rtl/sample_capture.sv
// Triggered capture of SAMPLES consecutive samples into a shadow buffer, published atomically.
// Latency: frame_ready pulses the cycle after the last sample; data_out/forced update at the end of that cycle.
// Backpressure: none; sample_valid=0 cycles are skipped, a sample offered in the publish cycle is dropped.
module sample_capture #(
    parameter int WIDTH   = osc_pkg::SAMPLE_W,
    parameter int SAMPLES = osc_pkg::SAMPLES,
    parameter int TIMEOUT = 4095
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sample_in,
    input  logic             sample_valid,
    input  logic             arm,
    input  logic             continuous,
    input  logic             abort,
    input  logic [WIDTH-1:0] trig_level,
    input  logic             trig_falling,
    output logic [WIDTH-1:0] data_out [0:SAMPLES-1],
    output logic             frame_ready,
    output logic             forced,
    output logic             busy
);

    import osc_pkg::*;

    localparam int IDX_W = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SAMPLES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    capture_state_t   state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic             prev_vld_q, prev_vld_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic             fpend_q, fpend_d;
    logic             forced_q, forced_d;
    logic [WIDTH-1:0] shadow_q [0:SAMPLES-1];
    logic [WIDTH-1:0] shadow_d [0:SAMPLES-1];
    logic [WIDTH-1:0] dout_q   [0:SAMPLES-1];
    logic [WIDTH-1:0] dout_d   [0:SAMPLES-1];

    logic hit;
    logic timeout_hit;

    trigger_detect #(.WIDTH(WIDTH)) u_trig (
        .prev         (prev_q),
        .prev_valid   (prev_vld_q),
        .sample_in    (sample_in),
        .trig_level   (trig_level),
        .trig_falling (trig_falling),
        .hit          (hit)
    );

    // A real crossing on the same sample wins over the timeout.
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST) && !hit;

    // Next-state logic: arm/trigger/capture/publish, with abort overriding everything.
    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        prev_vld_d  = prev_vld_q;
        cnt_d       = cnt_q;
        wr_idx_d    = wr_idx_q;
        fpend_d     = fpend_q;
        forced_d    = forced_q;
        shadow_d    = shadow_q;
        dout_d      = dout_q;
        frame_ready = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (arm) begin
                    state_d    = ST_ARMED;
                    prev_vld_d = 1'b0;
                    cnt_d      = '0;
                end
            end
            ST_ARMED: begin
                if (sample_valid) begin
                    if (hit || timeout_hit) begin
                        shadow_d[0] = sample_in;
                        wr_idx_d    = IDX_W'(1);
                        fpend_d     = !hit;
                        state_d     = ST_CAPTURE;
                    end else begin
                        prev_d     = sample_in;
                        prev_vld_d = 1'b1;
                        if (TIMEOUT != 0) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
            end
            ST_CAPTURE: begin
                if (sample_valid) begin
                    shadow_d[wr_idx_q] = sample_in;
                    wr_idx_d           = wr_idx_q + IDX_W'(1);
                    if (wr_idx_q == LAST_IDX) begin
                        state_d = ST_PUBLISH;
                    end
                end
            end
            ST_PUBLISH: begin
                frame_ready = 1'b1;
                dout_d      = shadow_q;
                forced_d    = fpend_q;
                if (continuous) begin
                    state_d    = ST_ARMED;
                    prev_vld_d = 1'b0;
                    cnt_d      = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort) begin
            state_d     = ST_IDLE;
            frame_ready = 1'b0;
            dout_d      = dout_q;
            forced_d    = forced_q;
        end
    end

    // Control and published-frame registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
            cnt_q      <= '0;
            wr_idx_q   <= '0;
            fpend_q    <= 1'b0;
            forced_q   <= 1'b0;
            for (int i = 0; i < SAMPLES; i++) begin
                dout_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
            cnt_q      <= cnt_d;
            wr_idx_q   <= wr_idx_d;
            fpend_q    <= fpend_d;
            forced_q   <= forced_d;
            dout_q     <= dout_d;
        end
    end

    // Shadow buffer needs no reset: it is only read after a full frame has been written.
    always_ff @(posedge clk) begin
        shadow_q <= shadow_d;
    end

    assign data_out = dout_q;
    assign forced   = forced_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: doc/sample_capture.md
Name: sample_capture

Overview:
- Producer side of the 80-sample frame consumed by the statistics block (average/min/max) and the waveform renderer.
- Accepts the ADC sample stream and waits for a level-crossing trigger, or forces a trigger after a timeout.
- Captures SAMPLES consecutive samples into a shadow buffer, then publishes them atomically as a parallel array with a one-cycle frame_ready pulse.

Parameters:
- SAMPLES, 80, frame length; the data_out array is [0:SAMPLES-1].
- WIDTH, 12, sample width in bits.
- TIMEOUT, 4095, number of valid samples in ARMED before a forced trigger; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- sample_in  in  WIDTH  ADC sample
- sample_valid  in  1  sample_in is valid this cycle
- arm  in  1  start one acquisition (single-cycle pulse or level)
- continuous  in  1  1 = re-arm automatically after each frame
- abort  in  1  cancel the acquisition and return to IDLE
- trig_level  in  WIDTH  trigger threshold, unsigned
- trig_falling  in  1  0 = rising-edge trigger, 1 = falling-edge trigger
- data_out  out  WIDTH x SAMPLES  published frame, index 0 = trigger sample
- frame_ready  out  1  one-cycle pulse when data_out updates
- forced  out  1  last published frame came from a timeout, not a crossing
- busy  out  1  state != IDLE

Behaviour:
- Clock/reset: one clock (clk); reset rst is synchronous and active-high. All registers update on posedge clk.
- Reset values: state=IDLE, data_out all 0, frame_ready=0, forced=0, busy=0, all counters 0, prev_valid=0.
- States: IDLE, ARMED, CAPTURE, PUBLISH.
- IDLE -> ARMED when arm=1.
  - On entry to ARMED: prev_valid=0, timeout counter=0.
- ARMED, on each cycle with sample_valid=1:
  - Rising trigger: prev_valid && prev < trig_level && sample_in >= trig_level.
  - Falling trigger: prev_valid && prev > trig_level && sample_in <= trig_level.
  - Forced trigger: TIMEOUT != 0 && counter == TIMEOUT-1 and no real trigger this sample.
  - A real trigger takes priority over a forced trigger on the same sample.
  - Otherwise: prev <= sample_in, prev_valid <= 1, counter++.
- On any trigger:
  - The triggering sample is written to shadow[0], wr_idx <= 1.
  - forced_pending is set to 1 for a forced trigger, 0 for a real trigger.
  - Next state is CAPTURE.
- CAPTURE:
  - Each valid sample is written to shadow[wr_idx], then wr_idx++.
  - When the sample written is at index SAMPLES-1, next state is PUBLISH.
  - Cycles with sample_valid=0 are ignored; there are no gaps in the frame.
- PUBLISH (exactly 1 cycle):
  - data_out <= shadow, forced <= forced_pending, frame_ready=1.
  - Next state: ARMED if continuous=1, else IDLE.
  - A sample_valid arriving in the PUBLISH cycle is dropped; it is not used as prev.
- Latency: frame_ready asserts the cycle after the last (SAMPLES-th) sample is accepted.
- data_out is stable between pulses; it never shows a partially captured frame.
- Comparisons are unsigned WIDTH-bit, with no arithmetic widening.
- wr_idx and the timeout counter are sized with $clog2; neither wraps in normal operation.
- Boundary conditions:
  - abort has priority over every other event in every state. Next state is IDLE; data_out and forced are retained; shadow contents are don't-care.
  - arm while busy=1 is ignored.
  - arm and abort in the same cycle: abort wins.
  - trig_level=0 with rising trigger: the condition prev<0 is never true, so only a forced trigger can start a capture (documented behaviour).
  - trig_level=4095 with falling trigger: the condition prev>4095 is never true, so likewise only a forced trigger can start a capture.
  - trig_level and trig_falling are sampled live each cycle and are not latched.
  - rst in mid-CAPTURE: full reset; no frame_ready pulse is issued.

Decomposition:
- Shared package osc_pkg holds:
  - the sample_t typedef (logic [WIDTH-1:0]) and the frame_t unpacked-array typedef, used by both this block and the statistics block;
  - the SAMPLES=80 constant;
  - the capture_state_t enum.
- One sub-module: trigger_detect, which is combinational. Inputs: prev, prev_valid, sample_in, trig_level, trig_falling. Output: hit.
- Shadow buffer, counters and FSM stay in the top-level module.

Test Plan:
- Rising trigger, trig_level=2048: stream ramp 2000,2040,2050,2060,... -> shadow[0]=2050; after 80 valid samples, frame_ready pulses once; data_out[0]=2050, data_out[79]=2050+79*10 ramp value; forced=0.
- Gapped valid: toggle sample_valid 1/0 during CAPTURE -> data_out holds 80 consecutive valid samples with no duplicates; frame_ready occurs 1 cycle after the 80th valid sample.
- Timeout, TIMEOUT=16: constant sample 100, trig_level=2048 -> forced trigger on the 16th valid sample; frame of 80 values of 100; forced=1.
- Falling trigger, trig_level=1000: sequence 1500,1200,900 -> capture starts at 900. Separately, with continuous=1 -> a second frame_ready pulse follows without re-asserting arm, and busy stays 1.
- abort at sample 40 of CAPTURE -> state IDLE, busy=0, no frame_ready; data_out is unchanged from the previous frame.
- rst asserted mid-CAPTURE for 1 cycle -> data_out all 0, frame_ready=0, busy=0; a subsequent arm plus trigger yields a normal frame.
